// File: rtl/alu_seq_ctrl.sv
// Operand sequencer for the 8-bit ALU: FIFO-buffered operations, one in flight,
// registered result with zero-divisor flag. Optional macro ALU_SEQ_STATS_EN adds op/error counters.
module alu_seq_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    input  logic [3:0]  in_cmd,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_cmd,
    output logic        alu_en,
    input  logic [15:0] alu_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic [3:0]  res_cmd,
    output logic        res_err
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0] stat_ops,
    output logic [15:0] stat_errs
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [3:0] CMD_DIV = 4'b0011;
    localparam logic [3:0] CMD_MOD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESULT
    } state_t;

    state_t state_reg, state_next;

    // Entry layout: {cmd, a, b}
    logic [19:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic [7:0]  alu_a_reg, alu_b_reg;
    logic [3:0]  alu_cmd_reg;
    logic        alu_en_reg;
    logic        res_valid_reg;
    logic [15:0] res_data_reg;
    logic [3:0]  res_cmd_reg;
    logic        res_err_reg;

    logic push;
    logic pop;
    logic fifo_nonempty;
    logic zero_div;

    assign in_ready      = (count_reg != CW'(DEPTH));
    assign push          = in_valid && in_ready;
    assign fifo_nonempty = (count_reg != '0);
    assign zero_div      = ((alu_cmd_reg == CMD_DIV) || (alu_cmd_reg == CMD_MOD)) && (alu_b_reg == 8'd0);

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fifo_nonempty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = RESULT;
            RESULT: begin
                if (res_ready) begin
                    if (fifo_nonempty) begin
                        pop        = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Storage carries no reset; emptiness is tracked solely by count_reg.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {in_cmd, in_a, in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_cmd_reg   <= '0;
            alu_en_reg    <= 1'b0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_cmd_reg   <= '0;
            res_err_reg   <= 1'b0;
        end else begin
            if (pop) begin
                {alu_cmd_reg, alu_a_reg, alu_b_reg} <= mem[rd_ptr_reg];
            end
            alu_en_reg    <= (state_next == ISSUE) || (state_next == CAPTURE);
            res_valid_reg <= (state_next == RESULT);
            // The ALU bus is undefined for a zero divisor, so it is replaced outright.
            if (state_reg == CAPTURE) begin
                res_data_reg <= zero_div ? 16'hFFFF : alu_out;
                res_cmd_reg  <= alu_cmd_reg;
                res_err_reg  <= zero_div;
            end
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_ops_reg;
    logic [15:0] stat_errs_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops_reg  <= '0;
            stat_errs_reg <= '0;
        end else if (res_valid_reg && res_ready) begin
            if (stat_ops_reg != 16'hFFFF) begin
                stat_ops_reg <= stat_ops_reg + 16'd1;
            end
            if (res_err_reg && (stat_errs_reg != 16'hFFFF)) begin
                stat_errs_reg <= stat_errs_reg + 16'd1;
            end
        end
    end

    assign stat_ops  = stat_ops_reg;
    assign stat_errs = stat_errs_reg;
`endif

    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_cmd   = alu_cmd_reg;
    assign alu_en    = alu_en_reg;
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_cmd   = res_cmd_reg;
    assign res_err   = res_err_reg;

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Operand sequencer directly upstream of the 8-bit `alu` datapath. It accepts ALU operations from a valid/ready producer and buffers them in a small FIFO. It issues one operation at a time onto the ALU's `a`/`b`/`command`/`enable` pins and captures the 16-bit tri-stated `out` into a registered result. It presents that result, with a divide/modulo-by-zero flag, on a valid/ready consumer interface.

## Interface
- `DEPTH`, default 4: operation FIFO entries; power of two, 2..16.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: producer has an operation.
- `in_ready` output 1: FIFO not full; transfer when `in_valid && in_ready`.
- `in_a` input 8: operand a.
- `in_b` input 8: operand b.
- `in_cmd` input 4: ALU command code (0000 add … 1111 mod).
- `alu_a` output 8: operand a to ALU, registered.
- `alu_b` output 8: operand b to ALU, registered.
- `alu_cmd` output 4: command to ALU, registered.
- `alu_en` output 1: ALU output enable, registered.
- `alu_out` input 16: ALU result bus (Z when `alu_en`=0).
- `res_valid` output 1: result available.
- `res_ready` input 1: consumer accepts; transfer when `res_valid && res_ready`.
- `res_data` output 16: captured result.
- `res_cmd` output 4: command that produced `res_data`.
- `res_err` output 1: command was div (0011) or mod (1111) with b==0.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESULT.
- IDLE: if FIFO is non-empty, pop the head into `alu_a`/`alu_b`/`alu_cmd` and go to ISSUE.
- ISSUE: `alu_en`=1; operands held stable (settle cycle); go to CAPTURE.
- CAPTURE: `alu_en`=1. At the clock edge, register `alu_out` into `res_data`, `alu_cmd` into `res_cmd`, and the zero-divisor check into `res_err`; go to RESULT.
- Zero divisor: if `alu_cmd` is 0011 or 1111 and `alu_b`==0, `res_data`=16'hFFFF and `res_err`=1. `alu_out` is ignored in this case.
- RESULT: `res_valid`=1 and outputs held until handshake. On handshake, go to ISSUE if the FIFO is non-empty (popping the head on the same edge); otherwise go to IDLE.
- Only one operation is in flight. Results return in acceptance order.
- FIFO push: on `in_valid && in_ready`. `in_ready` = !full, depending only on the registered count (no same-cycle push-through when full).
- Simultaneous push and pop: both take effect and the count is unchanged. Push into an empty FIFO is not visible to the FSM until the next cycle.
- Pointers wrap modulo `DEPTH`. The count is DEPTH+1 states wide.

## Timing
- Reset values: state IDLE, FIFO empty, `in_ready`=1, `alu_a`/`alu_b`=0, `alu_cmd`=0, `alu_en`=0, `res_valid`=0, `res_data`=0, `res_cmd`=0, `res_err`=0.
- Latency from accept at edge N (FIFO previously empty, FSM idle):
  - IDLE pops at edge N+1.
  - ISSUE during cycle N+1→N+2.
  - CAPTURE during N+2→N+3.
  - `res_valid` high after edge N+3.
- Back-to-back throughput: one result per 3 cycles with `res_ready` tied high.
- `alu_en` is high only in ISSUE and CAPTURE. It is low in IDLE and RESULT so the ALU bus floats.
- Reset mid-operation: all state returns to reset values on that edge. The FIFO contents and the in-flight result are discarded.
- `res_data`/`res_cmd`/`res_err` must not change while `res_valid`=1 without a handshake.

## Configuration
- Macro: `ALU_SEQ_STATS_EN`.
- Defined: adds outputs `stat_ops` (16-bit) and `stat_errs` (16-bit). Both reset to 0. `stat_ops` increments on each result handshake; `stat_errs` increments on each handshake with `res_err`=1. Both saturate at 16'hFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Add: a=200, b=100, cmd 0000, `res_ready`=1 → `res_data`=16'd300, `res_err`=0. `res_valid` rises 3 edges after accept.
- Multiply: a=255, b=255, cmd 0010 → `res_data`=16'hFE01.
- Divide by zero: a=10, b=0, cmd 0011 → `res_data`=16'hFFFF, `res_err`=1. Then mod 17%5 (cmd 1111) → 16'd2, `res_err`=0.
- Backpressure/full (`DEPTH`=4), `res_ready`=0, six back-to-back pushes:
  - Five are accepted: one in flight plus four in the FIFO.
  - `in_ready` is low at the sixth.
  - Releasing `res_ready` drains the results in push order.
- Reset mid-flight: assert `rst` during CAPTURE → next cycle `res_valid`=0, `alu_en`=0, `in_ready`=1, and no stale result appears afterwards.
- With `ALU_SEQ_STATS_EN`: three ops including one div-by-zero → `stat_ops`=3, `stat_errs`=1.
